// File: rtl/elastic_pipeline_if.sv
// Valid/ready bus carrying an address and transaction ID.
// The producer side is the master, the consumer side the slave.
interface elastic_pipeline_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int ID_WIDTH      = 4
);
    logic [ADDRESS_WIDTH-1:0] address;
    logic [ID_WIDTH-1:0]      id;
    logic                     valid;
    logic                     ready;

    modport master (
        output address,
        output id,
        output valid,
        input  ready
    );

    modport slave (
        input  address,
        input  id,
        input  valid,
        output ready
    );
endinterface

// File: rtl/elastic_pipeline.sv
// Elastic {address,id} pipeline: per-stage offset, bubble collapsing, flush-by-ID.
// Define PIPELINE_FLUSH_CNT_EN to add the saturating flush_count output.
module elastic_pipeline #(
    parameter int DEPTH         = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int ID_WIDTH      = 4,
    parameter int OFFSET_STEP   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    elastic_pipeline_if.slave          in_bus,
    elastic_pipeline_if.master         out_bus,
    input  logic                       in_flush,
    input  logic [ID_WIDTH-1:0]        in_flush_id,
    input  logic                       in_stall,
`ifdef PIPELINE_FLUSH_CNT_EN
    output logic [15:0]                flush_count,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = $clog2(DEPTH + 2);

    logic [DEPTH-1:0]         v;
    logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
    logic [ID_WIDTH-1:0]      id_q   [DEPTH];

    logic [DEPTH-1:0]         kill;
    logic [DEPTH-1:0]         ve;
    logic [DEPTH-1:0]         rdy;
    logic                     in_kill;

    logic [DEPTH-1:0]         prev_v;
    logic [ADDRESS_WIDTH-1:0] prev_addr [DEPTH];
    logic [ID_WIDTH-1:0]      prev_id   [DEPTH];

    function automatic logic [ADDRESS_WIDTH-1:0] stage_offset(input int k);
        stage_offset = ADDRESS_WIDTH'(k + 1) * ADDRESS_WIDTH'(OFFSET_STEP);
    endfunction

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            kill[k] = in_flush && v[k] && (id_q[k] == in_flush_id);
            ve[k]   = v[k] && !kill[k];
        end
    end

    // Ready ripples back from the consumer; any empty stage re-enables everything behind it.
    always_comb begin
        logic r;
        r = out_bus.ready && !in_stall;
        rdy = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            r = !in_stall && (!ve[k] || r);
            rdy[k] = r;
        end
    end

    assign in_kill      = in_flush && (in_bus.id == in_flush_id);
    assign in_bus.ready = rdy[0];

    always_comb begin
        prev_v[0]    = in_bus.valid && !in_kill;
        prev_addr[0] = in_bus.address;
        prev_id[0]   = in_bus.id;
        for (int k = 1; k < DEPTH; k++) begin
            prev_v[k]    = ve[k-1];
            prev_addr[k] = addr_q[k-1];
            prev_id[k]   = id_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= '0;
                id_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v[k]      <= prev_v[k];
                    addr_q[k] <= prev_addr[k] + stage_offset(k);
                    id_q[k]   <= prev_id[k];
                end else begin
                    v[k] <= ve[k];
                end
            end
        end
    end

    assign out_bus.valid   = ve[DEPTH-1] && !in_stall;
    assign out_bus.address = addr_q[DEPTH-1];
    assign out_bus.id      = id_q[DEPTH-1];

    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count = count + CW'(v[k]);
        end
    end

`ifdef PIPELINE_FLUSH_CNT_EN
    logic [KW-1:0] n_kill;
    logic [16:0]   fc_sum;

    // A killed input counts only when its handshake actually completes.
    always_comb begin
        n_kill = KW'(in_bus.valid && rdy[0] && in_kill);
        for (int k = 0; k < DEPTH; k++) begin
            n_kill = n_kill + KW'(kill[k]);
        end
        fc_sum = {1'b0, flush_count} + 17'(n_kill);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flush_count <= '0;
        end else if (fc_sum[16]) begin
            flush_count <= 16'hFFFF;
        end else begin
            flush_count <= fc_sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_elastic_pipeline.sv
// Randomized and directed bench for elastic_pipeline against a queue-based model.
// Honours PIPELINE_FLUSH_CNT_EN when the design is built with it.
module tb_elastic_pipeline;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int IW    = 4;
    localparam int STEP  = 3;
    localparam logic [AW-1:0] TOTAL = AW'(STEP * DEPTH * (DEPTH + 1) / 2);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_flush;
    logic [IW-1:0] in_flush_id;
    logic          in_stall;
    logic [2:0]    count;
`ifdef PIPELINE_FLUSH_CNT_EN
    logic [15:0]   flush_count;
`endif

    elastic_pipeline_if #(.ADDRESS_WIDTH(AW), .ID_WIDTH(IW)) in_bus ();
    elastic_pipeline_if #(.ADDRESS_WIDTH(AW), .ID_WIDTH(IW)) out_bus ();

    elastic_pipeline #(
        .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW), .OFFSET_STEP(STEP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_bus(in_bus),
        .out_bus(out_bus),
        .in_flush(in_flush),
        .in_flush_id(in_flush_id),
        .in_stall(in_stall),
`ifdef PIPELINE_FLUSH_CNT_EN
        .flush_count(flush_count),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [AW+IW-1:0] q[$];
    logic [IW-1:0]    out_ids[$];
    int               fc_m = 0;
    int               cyc = 0;
    int               xfer_n = 0;
    int               first_cyc = 0;
    int               last_cyc = 0;
    logic             last_ov, last_ir;
    logic [AW-1:0]    last_addr;
    logic [2:0]       last_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model();
        int eff;
        int kills;
        logic exp_rdy;
        logic [AW+IW-1:0] keep[$];
        last_ov   = out_bus.valid;
        last_ir   = in_bus.ready;
        last_addr = out_bus.address;
        last_cnt  = count;
        if (!reset) begin
            q.delete();
            fc_m = 0;
            return;
        end
        eff = 0;
        foreach (q[i]) if (!(in_flush && q[i][IW-1:0] == in_flush_id)) eff++;
        exp_rdy = !in_stall && (eff < DEPTH || out_bus.ready);
        check("count", 64'(count), 64'(q.size()));
        check("in_ready", 64'(in_bus.ready), 64'(exp_rdy));
        if (in_stall) check("stall_out_valid", 64'(out_bus.valid), 64'd0);
`ifdef PIPELINE_FLUSH_CNT_EN
        check("flush_count", 64'(flush_count), 64'(fc_m));
`endif
        if (out_bus.valid && out_bus.ready) begin
            xfer_n++;
            if (xfer_n == 1) first_cyc = cyc;
            last_cyc = cyc;
            out_ids.push_back(out_bus.id);
            if (q.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                check("out_addr", 64'(out_bus.address), 64'(q[0][AW+IW-1:IW]));
                check("out_id", 64'(out_bus.id), 64'(q[0][IW-1:0]));
                void'(q.pop_front());
            end
        end
        kills = 0;
        foreach (q[i]) begin
            if (in_flush && q[i][IW-1:0] == in_flush_id) kills++;
            else keep.push_back(q[i]);
        end
        q = keep;
        if (in_bus.valid && exp_rdy) begin
            if (in_flush && in_bus.id == in_flush_id) kills++;
            else q.push_back({in_bus.address + TOTAL, in_bus.id});
        end
        fc_m = (fc_m + kills > 65535) ? 65535 : fc_m + kills;
    endtask

    task automatic step();
        @(negedge clk);
        model();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        in_bus.valid = 1'b0;
        in_flush = 1'b0;
        in_stall = 1'b0;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [IW-1:0] id);
        in_bus.valid = 1'b1;
        in_bus.address = a;
        in_bus.id = id;
        step();
    endtask

    task automatic drain();
        int n;
        idle_inputs();
        out_bus.ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 40) begin
            step();
            n++;
        end
        step();
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!last_ov && lat < 20);
        check(tag, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        logic [IW-1:0] ids[4];
        int fc_before;
        ids = '{4'd1, 4'd2, 4'd1, 4'd3};
        reset = 1'b0;
        idle_inputs();
        in_flush_id = '0;
        in_bus.address = '0;
        in_bus.id = '0;
        out_bus.ready = 1'b1;
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_bus.valid), 64'd0);
        check("rst_out_addr", 64'(out_bus.address), 64'd0);
        check("rst_out_id", 64'(out_bus.id), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_bus.ready), 64'd1);
        @(posedge clk);
        #1;

        send(32'h10, 4'd2);
        idle_inputs();
        wait_out("latency", DEPTH);
        check("addr_0x10", 64'(last_addr), 64'h2E);
        drain();

        send(32'hFFFF_FFF0, 4'd7);
        idle_inputs();
        wait_out("wrap_latency", DEPTH);
        check("addr_wrap", 64'(last_addr), 64'h0E);
        drain();

        xfer_n = 0;
        for (int i = 0; i < 8; i++) send($urandom, IW'(i));
        drain();
        check("stream_n", 64'(xfer_n), 64'd8);
        check("stream_gap", 64'(last_cyc - first_cyc), 64'd7);

        out_bus.ready = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom, 4'd9);
        idle_inputs();
        step();
        check("full_count", 64'(last_cnt), 64'd4);
        check("full_in_ready", 64'(last_ir), 64'd0);
        out_bus.ready = 1'b1;
        step();
        check("pop_out_valid", 64'(last_ov), 64'd1);
        check("pop_in_ready", 64'(last_ir), 64'd1);
        out_bus.ready = 1'b0;
        step();
        check("pop_count", 64'(last_cnt), 64'd3);
        drain();

        out_bus.ready = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom, ids[i]);
        idle_inputs();
        step();
        check("pre_flush_count", 64'(last_cnt), 64'd4);
`ifdef PIPELINE_FLUSH_CNT_EN
        fc_before = int'(flush_count);
`else
        fc_before = 0;
`endif
        in_flush = 1'b1;
        in_flush_id = 4'd1;
        step();
        in_flush = 1'b0;
        step();
        check("post_flush_count", 64'(last_cnt), 64'd2);
`ifdef PIPELINE_FLUSH_CNT_EN
        check("flush_count_delta", 64'(int'(flush_count) - fc_before), 64'd2);
`endif
        out_ids.delete();
        drain();
        check("flush_order_n", 64'(out_ids.size()), 64'd2);
        if (out_ids.size() == 2) begin
            check("flush_order0", 64'(out_ids[0]), 64'd2);
            check("flush_order1", 64'(out_ids[1]), 64'd3);
        end

        out_bus.ready = 1'b1;
        send($urandom, 4'd5);
        send($urandom, 4'd6);
        in_bus.valid = 1'b1;
        in_bus.id = 4'd5;
        in_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_flush = (i == 1);
            in_flush_id = 4'd5;
            step();
            check("stall_ov", 64'(last_ov), 64'd0);
            check("stall_ir", 64'(last_ir), 64'd0);
        end
        in_flush = 1'b0;
        check("stall_flush_count", 64'(last_cnt), 64'd1);
        in_stall = 1'b0;
        send($urandom, 4'd5);
        send($urandom, 4'd7);
        drain();

        out_bus.ready = 1'b0;
        for (int i = 0; i < 3; i++) send($urandom, IW'(i));
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("mid_rst_count", 64'(last_cnt), 64'd0);
        check("mid_rst_ov", 64'(last_ov), 64'd0);
        check("mid_rst_ir", 64'(last_ir), 64'd1);

        for (int i = 0; i < 400; i++) begin
            in_bus.valid = ($urandom % 4) != 0;
            in_bus.address = $urandom;
            in_bus.id = IW'($urandom % 4);
            out_bus.ready = ($urandom % 3) != 0;
            in_stall = ($urandom % 10) == 0;
            in_flush = ($urandom % 8) == 0;
            in_flush_id = IW'($urandom % 4);
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
